// File: rtl/spi_master_mcs_pkg.sv
// Shared types and helpers for the multi-slave SPI master.
package spi_master_mcs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_TRAIL = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // SPI modes packed as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // A zero or oversize frame length means a full-width frame
    function automatic int clamp_len(input int len, input int max_len);
        return (len == 0 || len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/spi_master_mcs_if.sv
// Command/result bus plus SPI pins of the SPI master.
// The master modport is the engine's view; slave is the view of whoever drives it.
interface spi_master_mcs_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CS     = 4
);
    localparam int LW  = $clog2(DATA_WIDTH) + 1;
    localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic                  start;
    logic                  ready;
    logic [CSW-1:0]        cs_sel;
    logic [LW-1:0]         len;
    logic                  cpol;
    logic                  cpha;
    logic                  lsb_first;
    logic [DATA_WIDTH-1:0] mosi_data;
    logic                  abort;
    logic [DATA_WIDTH-1:0] miso_data;
    logic                  valid;
    logic [2:0]            state;
    logic                  miso;
    logic                  mosi;
    logic                  spi_clk;
    logic [NUM_CS-1:0]     cs_n;

    modport master (
        input  start, cs_sel, len, cpol, cpha, lsb_first, mosi_data, abort, miso,
        output ready, miso_data, valid, state, mosi, spi_clk, cs_n
    );

    modport slave (
        output start, cs_sel, len, cpol, cpha, lsb_first, mosi_data, abort, miso,
        input  ready, miso_data, valid, state, mosi, spi_clk, cs_n
    );
endinterface

// File: rtl/spi_master_mcs_clk_gen.sv
// SCLK generator: divider down-counter, edge counter and lead/trail edge strobes.
// Strobes fire on the same clk edge that toggles the SCLK register.
module spi_master_mcs_clk_gen #(
    parameter int CLK_DIV = 3,
    parameter int CW      = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load,
    input  logic          cpol,
    output logic          lead_stb,
    output logic          trail_stb,
    output logic [CW-1:0] edge_cnt,
    output logic          sclk
);
    localparam int DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DVW-1:0] DIV_LOAD = DVW'(CLK_DIV - 1);

    logic [DVW-1:0] div_cnt;
    logic           stb;

    assign stb       = en && (div_cnt == '0);
    assign lead_stb  = stb && !edge_cnt[0];
    assign trail_stb = stb && edge_cnt[0];

    // Divider and edge counter idle at their start values outside RUN so the
    // first edge lands exactly CLK_DIV cycles after RUN entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= DIV_LOAD;
            edge_cnt <= '0;
            sclk     <= 1'b0;
        end else begin
            if (!en || load) begin
                div_cnt  <= DIV_LOAD;
                edge_cnt <= '0;
            end else if (stb) begin
                div_cnt  <= DIV_LOAD;
                edge_cnt <= edge_cnt + CW'(1);
            end else begin
                div_cnt  <= div_cnt - DVW'(1);
            end

            if (load)
                sclk <= cpol;
            else if (stb)
                sclk <= ~sclk;
        end
    end
endmodule

// File: rtl/spi_master_mcs.sv
// Multi-slave SPI master: command FSM, shift registers and chip-select decode.
//
//  state | meaning
//  IDLE  | ready for a command, CS high
//  LEAD  | CS low, first bit presented, DELAY cycles before first SCLK edge
//  RUN   | 2*len SCLK edges, shifting out and sampling in
//  TRAIL | CS still low, DELAY cycles after the last SCLK edge
//  GAP   | CS high, DELAY cycles before the next command can be taken
module spi_master_mcs
    import spi_master_mcs_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CS     = 4,
    parameter int CLK_DIV    = 3,
    parameter int DELAY      = 2
) (
    input logic              clk,
    input logic              rst,
    spi_master_mcs_if.master bus
);
    localparam int LW  = $clog2(DATA_WIDTH) + 1;
    localparam int IW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int TW  = $clog2(DELAY) + 1;
    localparam logic [TW-1:0] T_LOAD = TW'(DELAY - 1);

    state_t                state;
    logic [TW-1:0]         tmr;
    logic [LW-1:0]         len_q;
    logic                  cpol_q, cpha_q, lsb_q;
    logic [DATA_WIDTH-1:0] tx_q, rx_q, miso_data_q;
    logic [NUM_CS-1:0]     cs_n_q, cs_dec;
    logic                  mosi_q, valid_q;

    logic          lead_stb, trail_stb, sclk;
    logic [LW-1:0] edge_cnt, bit_num, drv_bit, len_in;
    logic [IW-1:0] smp_idx, drv_idx, first_idx;
    logic          accept, abort_now, tmr_tc, last_edge, smp_stb, drv_stb, first_bit;

    function automatic logic [LW-1:0] bit_pos(input logic [LW-1:0] b,
                                              input logic [LW-1:0] len,
                                              input logic          lsb);
        return lsb ? b : len - LW'(1) - b;
    endfunction

    assign accept    = (state == ST_IDLE) && bus.start;
    assign abort_now = bus.abort &&
                       (state == ST_LEAD || state == ST_RUN || state == ST_TRAIL);
    assign tmr_tc    = (tmr == '0);
    assign len_in    = LW'(clamp_len(int'(bus.len), DATA_WIDTH));
    assign first_idx = IW'(bus.lsb_first ? LW'(0) : len_in - LW'(1));
    assign first_bit = bus.mosi_data[first_idx];

    // Bit k of the frame occupies SCLK edges 2k (leading) and 2k+1 (trailing)
    assign bit_num   = edge_cnt >> 1;
    assign last_edge = trail_stb && (bit_num == len_q - LW'(1));
    assign smp_stb   = cpha_q ? trail_stb : lead_stb;
    assign drv_stb   = cpha_q ? lead_stb : (trail_stb && !last_edge);
    assign drv_bit   = cpha_q ? bit_num : bit_num + LW'(1);
    assign smp_idx   = IW'(bit_pos(bit_num, len_q, lsb_q));
    assign drv_idx   = IW'(bit_pos(drv_bit, len_q, lsb_q));

    // One-hot active-low select for the requested slave
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (NUM_CS == 1 || bus.cs_sel == CSW'(i))
                cs_dec[i] = 1'b0;
    end

    spi_master_mcs_clk_gen #(
        .CLK_DIV (CLK_DIV),
        .CW      (LW)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (state == ST_RUN),
        .load      (accept || abort_now),
        .cpol      (accept ? bus.cpol : cpol_q),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb),
        .edge_cnt  (edge_cnt),
        .sclk      (sclk)
    );

    // Frame sequencing with registered CS, MOSI and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            tmr         <= '0;
            len_q       <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsb_q       <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            cs_n_q      <= '1;
            mosi_q      <= 1'b0;
            valid_q     <= 1'b0;
            miso_data_q <= '0;
        end else begin
            valid_q <= 1'b0;
            if (abort_now) begin
                state  <= ST_GAP;
                tmr    <= T_LOAD;
                cs_n_q <= '1;
                mosi_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (bus.start) begin
                        state  <= ST_LEAD;
                        tmr    <= T_LOAD;
                        len_q  <= len_in;
                        cpol_q <= bus.cpol;
                        cpha_q <= bus.cpha;
                        lsb_q  <= bus.lsb_first;
                        tx_q   <= bus.mosi_data;
                        rx_q   <= '0;
                        cs_n_q <= cs_dec;
                        mosi_q <= first_bit;
                    end
                    ST_LEAD: begin
                        if (tmr_tc) state <= ST_RUN;
                        else        tmr   <= tmr - TW'(1);
                    end
                    ST_RUN: begin
                        if (smp_stb) rx_q[smp_idx] <= bus.miso;
                        if (drv_stb) mosi_q <= tx_q[drv_idx];
                        if (last_edge) begin
                            state <= ST_TRAIL;
                            tmr   <= T_LOAD;
                        end
                    end
                    ST_TRAIL: begin
                        if (tmr_tc) begin
                            state       <= ST_GAP;
                            tmr         <= T_LOAD;
                            cs_n_q      <= '1;
                            mosi_q      <= 1'b0;
                            valid_q     <= 1'b1;
                            miso_data_q <= rx_q;
                        end else begin
                            tmr <= tmr - TW'(1);
                        end
                    end
                    ST_GAP: begin
                        if (tmr_tc) state <= ST_IDLE;
                        else        tmr   <= tmr - TW'(1);
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.ready     = (state == ST_IDLE);
    assign bus.state     = state;
    assign bus.cs_n      = cs_n_q;
    assign bus.mosi      = mosi_q;
    assign bus.spi_clk   = sclk;
    assign bus.miso_data = miso_data_q;
    assign bus.valid     = valid_q;
endmodule

// File: tb/tb_spi_master_mcs.sv
// Directed bench for spi_master_mcs with a result scoreboard.
module tb_spi_master_mcs;
    import spi_master_mcs_pkg::*;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic miso_tie = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    int   edges = 0;
    int   rises = 0;
    logic fall_log[$];
    logic sclk_prev = 1'b0;
    logic valid_prev = 1'b0;

    int   acc_cyc, e0, r0, f0;

    spi_master_mcs_if #(.DATA_WIDTH(16), .NUM_CS(4)) bus ();

    spi_master_mcs #(
        .DATA_WIDTH (16),
        .NUM_CS     (4),
        .CLK_DIV    (2),
        .DELAY      (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.miso = miso_tie ? 1'b1 : bus.mosi;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // SCLK edge tracker; MOSI is logged at every falling SCLK edge
    always @(negedge clk) begin
        if (bus.spi_clk !== sclk_prev) begin
            edges++;
            if (bus.spi_clk) rises++;
            else             fall_log.push_back(bus.mosi);
        end
        sclk_prev = bus.spi_clk;
    end

    // Scoreboard monitor: every valid pulse pops one expected result
    always @(negedge clk) begin
        exp_t e;
        if (bus.valid) begin
            check("valid_pulse_width", 32'(valid_prev), 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: valid=1 data=0x%0h at cycle %0d, expected no result", bus.miso_data, cyc);
            end else begin
                e = sb.pop_front();
                check("rx_data", 32'(bus.miso_data), 32'(e.data));
                check("valid_latency", cyc, e.due);
            end
        end
        valid_prev = bus.valid;
    end

    task automatic wait_ready(input int budget);
        int n = 0;
        @(negedge clk);
        while (!bus.ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready=%0b after %0d cycles, expected 1", bus.ready, budget);
        end
    endtask

    // Issue one command; snapshots edge counters once LEAD is underway
    task automatic issue(input logic [1:0] sel, input logic [4:0] len, input logic [1:0] mode,
                         input logic lsb, input logic [15:0] data, input logic [15:0] exp_data,
                         input int len_eff, input bit push);
        wait_ready(200);
        bus.cs_sel    = sel;
        bus.len       = len;
        bus.cpol      = mode[1];
        bus.cpha      = mode[0];
        bus.lsb_first = lsb;
        bus.mosi_data = data;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (push) sb.push_back(exp_t'{data: exp_data, due: acc_cyc + 4 + 4 * len_eff});
        bus.start = 1'b0;
        @(negedge clk);
        #1;
        e0 = edges;
        r0 = rises;
        f0 = fall_log.size();
    endtask

    initial begin
        logic [11:0] seq;
        int          acc1, acc2, n;

        bus.start = 0; bus.cs_sel = 0; bus.len = 0; bus.cpol = 0; bus.cpha = 0;
        bus.lsb_first = 0; bus.mosi_data = 0; bus.abort = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", 32'(bus.cs_n), 32'hF);
        check("rst_sclk", 32'(bus.spi_clk), 32'd0);
        check("rst_mosi", 32'(bus.mosi), 32'd0);
        check("rst_miso_data", 32'(bus.miso_data), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_state", 32'(bus.state), 32'd0);
        @(negedge clk) rst = 1'b0;

        // Mode 0, 8 bits, slave 2
        issue(2'd2, 5'd8, MODE0, 1'b0, 16'h00A5, 16'h00A5, 8, 1);
        check("t1_cs_n", 32'(bus.cs_n), 32'hB);
        check("t1_lead_mosi", 32'(bus.mosi), 32'd1);
        check("t1_busy", 32'(bus.ready), 32'd0);
        wait_ready(100);
        check("t1_rises", rises - r0, 8);
        check("t1_edges", edges - e0, 16);
        check("t1_cs_idle", 32'(bus.cs_n), 32'hF);
        check("t1_mosi_idle", 32'(bus.mosi), 32'd0);

        // Mode 3, 16 bits, MISO held high
        miso_tie = 1'b1;
        issue(2'd0, 5'd16, MODE3, 1'b0, 16'hBEEF, 16'hFFFF, 16, 1);
        check("t2_sclk_lead", 32'(bus.spi_clk), 32'd1);
        check("t2_cs_n", 32'(bus.cs_n), 32'hE);
        wait_ready(200);
        check("t2_sclk_idle", 32'(bus.spi_clk), 32'd1);
        check("t2_edges", edges - e0, 32);
        miso_tie = 1'b0;

        // Mode 1, LSB first, 12 bits
        issue(2'd1, 5'd12, MODE1, 1'b1, 16'h0123, 16'h0123, 12, 1);
        wait_ready(200);
        seq = '0;
        for (int i = 0; i < 12; i++)
            if (f0 + i < fall_log.size()) seq[i] = fall_log[f0 + i];
        check("t3_falls", fall_log.size() - f0, 12);
        check("t3_mosi_seq", 32'(seq), 32'h123);
        check("t3_sclk_idle", 32'(bus.spi_clk), 32'd0);

        // Length clamping
        issue(2'd3, 5'd0, MODE0, 1'b0, 16'hC3C3, 16'hC3C3, 16, 1);
        wait_ready(200);
        check("t4_len0_edges", edges - e0, 32);
        issue(2'd3, 5'd20, MODE0, 1'b0, 16'hC3C3, 16'hC3C3, 16, 1);
        wait_ready(200);
        check("t4_len20_edges", edges - e0, 32);

        // Abort after five SCLK edges
        issue(2'd0, 5'd16, MODE0, 1'b0, 16'h1234, 16'h0000, 16, 0);
        n = 0;
        while (edges - e0 < 5 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t5_edges_before_abort", edges - e0, 5);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check("t5_cs_high", 32'(bus.cs_n), 32'hF);
        check("t5_sclk_cpol", 32'(bus.spi_clk), 32'd0);
        check("t5_mosi", 32'(bus.mosi), 32'd0);
        check("t5_state_gap", 32'(bus.state), 32'(ST_GAP));
        @(posedge clk);
        #1;
        check("t5_ready_1cyc", 32'(bus.ready), 32'd0);
        @(posedge clk);
        #1;
        check("t5_ready_2cyc", 32'(bus.ready), 32'd1);
        check("t5_miso_kept", 32'(bus.miso_data), 32'hC3C3);

        // Back-to-back with start held, then a pulse while busy
        wait_ready(200);
        bus.cs_sel = 2'd1; bus.len = 5'd8; bus.cpol = 1'b0; bus.cpha = 1'b0;
        bus.lsb_first = 1'b0; bus.mosi_data = 16'h0055; bus.start = 1'b1;
        @(posedge clk);
        #1;
        acc1 = cyc;
        sb.push_back(exp_t'{data: 16'h0055, due: acc1 + 36});
        acc2 = acc1;
        n = 0;
        while (acc2 == acc1 && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.ready) begin
                @(posedge clk);
                #1;
                acc2 = cyc;
                sb.push_back(exp_t'{data: 16'h0055, due: acc2 + 36});
            end
        end
        bus.start = 1'b0;
        check("t6_accept_spacing", acc2 - acc1, 39);
        repeat (10) @(negedge clk);
        bus.mosi_data = 16'h00FF;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_ready(200);
        repeat (5) @(negedge clk);
        check("t6_no_queue_ready", 32'(bus.ready), 32'd1);
        check("t6_no_queue_cs", 32'(bus.cs_n), 32'hF);

        // Asynchronous reset in the middle of RUN
        issue(2'd3, 5'd16, MODE2, 1'b0, 16'hAAAA, 16'h0000, 16, 0);
        repeat (10) @(posedge clk);
        #3;
        check("t7_cs_active", 32'(bus.cs_n), 32'h7);
        rst = 1'b1;
        #1;
        check("t7_cs_n", 32'(bus.cs_n), 32'hF);
        check("t7_sclk", 32'(bus.spi_clk), 32'd0);
        check("t7_mosi", 32'(bus.mosi), 32'd0);
        check("t7_miso_data", 32'(bus.miso_data), 32'd0);
        check("t7_valid", 32'(bus.valid), 32'd0);
        check("t7_ready", 32'(bus.ready), 32'd1);
        check("t7_state", 32'(bus.state), 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (5) @(negedge clk);

        check("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
